servant_wb_arbiter: RTL

Two-master Wishbone arbiter placed between the requesters (master 0 = SERV CPU data bus, master 1 = DMA/loader) and the servant address-decode mux. It grants one master at a time with round-robin priority and holds the grant until the slave acks. It drops cyc for one cycle after every ack so the mux's registered ack cannot double-fire. A bus-timeout watchdog force-terminates stalled accesses, such as an accelerator BRAM that never acks, and latches error status.

---
 rtl/servant_arb_pkg.sv | 18 +
 rtl/servant_arb_watchdog.sv | 49 ++++
 rtl/servant_wb_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/servant_arb_pkg.sv
// servant_arb_pkg
//   Shared definitions for the servant two-master Wishbone arbiter:
//   FSM state encoding, default watchdog settings and master indices.
package servant_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } arb_state_e;

  localparam int          DEFAULT_TIMEOUT     = 64;
  localparam logic [31:0] DEFAULT_TIMEOUT_RDT = 32'hDEAD_BEEF;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/servant_arb_watchdog.sv
// servant_arb_watchdog
//   Counts cycles a granted access has waited for its ack and flags the
//   cycle in which the access must be force-terminated.
// Ports:
//   i_clk, i_rst    clock, synchronous active-high reset
//   i_clr           restart the count (new grant)
//   i_en            an access is in flight (arbiter busy)
//   i_ack           slave ack this cycle; a real ack suppresses the timeout
//   o_timeout_hit   force-terminate the current access this cycle
module servant_arb_watchdog
  import servant_arb_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_ack,
  output logic o_timeout_hit
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CW-1:0] cnt_q, cnt_d;

  // Only meaningful while busy; a TIMEOUT of 1 would otherwise match the
  // idle count of zero.
  assign o_timeout_hit = (TIMEOUT != 0) && i_en && (cnt_q == LAST) && !i_ack;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr || !i_en) begin
      cnt_d = '0;
    end else if (!i_ack && !o_timeout_hit && (TIMEOUT != 0)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/servant_wb_arbiter.sv
// servant_wb_arbiter
//   Round-robin two-master Wishbone arbiter in front of the servant address
//   decode mux. A grant is held until ack; the arbiter always passes through
//   IDLE after an ack so the mux's registered ack cannot fire twice. A
//   watchdog force-acks stalled accesses and records the first one.
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_m0_* / o_m0_*              master 0 (CPU data bus) request / response
//   i_m1_* / o_m1_*              master 1 (DMA / loader) request / response
//   o_s_* / i_s_*                towards / from the address decode mux
//   o_err, o_err_adr, o_err_master  sticky record of the first timeout
//   i_err_clr                    clears the error record
module servant_wb_arbiter
  import servant_arb_pkg::*;
#(
  parameter int          TIMEOUT     = DEFAULT_TIMEOUT,
  parameter logic [31:0] TIMEOUT_RDT = DEFAULT_TIMEOUT_RDT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_m0_adr,
  input  logic [31:0] i_m0_dat,
  input  logic [3:0]  i_m0_sel,
  input  logic        i_m0_we,
  input  logic        i_m0_cyc,
  output logic [31:0] o_m0_rdt,
  output logic        o_m0_ack,
  input  logic [31:0] i_m1_adr,
  input  logic [31:0] i_m1_dat,
  input  logic [3:0]  i_m1_sel,
  input  logic        i_m1_we,
  input  logic        i_m1_cyc,
  output logic [31:0] o_m1_rdt,
  output logic        o_m1_ack,
  output logic [31:0] o_s_adr,
  output logic [31:0] o_s_dat,
  output logic [3:0]  o_s_sel,
  output logic        o_s_we,
  output logic        o_s_cyc,
  input  logic [31:0] i_s_rdt,
  input  logic        i_s_ack,
  output logic        o_err,
  output logic [31:0] o_err_adr,
  output logic        o_err_master,
  input  logic        i_err_clr
);

  arb_state_e  state_q;
  logic        last_grant_q;
  logic        err_q;
  logic [31:0] err_adr_q;
  logic        err_master_q;

  logic busy0, busy1, busy;
  logic gnt_cyc;
  logic wd_hit;
  logic hit;

  assign busy0   = (state_q == BUSY0);
  assign busy1   = (state_q == BUSY1);
  assign busy    = busy0 | busy1;
  assign gnt_cyc = (busy0 & i_m0_cyc) | (busy1 & i_m1_cyc);

  servant_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_clr         (!busy),
    .i_en          (busy),
    .i_ack         (i_s_ack),
    .o_timeout_hit (wd_hit)
  );

  // An access the master has already abandoned is not force-acked and
  // does not count as an error.
  assign hit = wd_hit & gnt_cyc;

  always_comb begin
    o_s_adr = '0;
    o_s_dat = '0;
    o_s_sel = '0;
    o_s_we  = 1'b0;
    o_s_cyc = 1'b0;
    case (state_q)
      BUSY0: begin
        o_s_adr = i_m0_adr;
        o_s_dat = i_m0_dat;
        o_s_sel = i_m0_sel;
        o_s_we  = i_m0_we;
        o_s_cyc = i_m0_cyc;
      end
      BUSY1: begin
        o_s_adr = i_m1_adr;
        o_s_dat = i_m1_dat;
        o_s_sel = i_m1_sel;
        o_s_we  = i_m1_we;
        o_s_cyc = i_m1_cyc;
      end
      default: ;
    endcase
  end

  assign o_m0_ack = busy0 & (i_s_ack | hit);
  assign o_m1_ack = busy1 & (i_s_ack | hit);
  assign o_m0_rdt = hit ? TIMEOUT_RDT : i_s_rdt;
  assign o_m1_rdt = hit ? TIMEOUT_RDT : i_s_rdt;

  assign o_err        = err_q;
  assign o_err_adr    = err_adr_q;
  assign o_err_master = err_master_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      last_grant_q <= M1;
      err_q        <= 1'b0;
      err_adr_q    <= '0;
      err_master_q <= M0;
    end else begin
      case (state_q)
        IDLE: begin
          // On a tie the master that did not win last time gets the bus.
          if (i_m0_cyc && i_m1_cyc) begin
            if (last_grant_q == M1) begin
              state_q      <= BUSY0;
              last_grant_q <= M0;
            end else begin
              state_q      <= BUSY1;
              last_grant_q <= M1;
            end
          end else if (i_m0_cyc) begin
            state_q      <= BUSY0;
            last_grant_q <= M0;
          end else if (i_m1_cyc) begin
            state_q      <= BUSY1;
            last_grant_q <= M1;
          end
        end
        BUSY0: begin
          if (i_s_ack || hit || !i_m0_cyc) state_q <= IDLE;
        end
        BUSY1: begin
          if (i_s_ack || hit || !i_m1_cyc) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // A clear in the same cycle as a new timeout yields the new record.
      if (hit && (!err_q || i_err_clr)) begin
        err_q        <= 1'b1;
        err_adr_q    <= o_s_adr;
        err_master_q <= busy1 ? M1 : M0;
      end else if (i_err_clr) begin
        err_q        <= 1'b0;
        err_adr_q    <= '0;
        err_master_q <= M0;
      end
    end
  end

endmodule
